// File: rtl/assert_ctl_hub.sv
// assert_ctl_hub: runtime assertion-control hub.
// Gates per-channel check results with on/off/kill/lock state, then produces
// registered failure pulses, saturating failure counters and a first-failure record.
module assert_ctl_hub #(
  parameter int unsigned        NUM_CH   = 4,
  parameter int unsigned        CNT_W    = 8,
  parameter logic [NUM_CH-1:0]  EN_RESET = '1,
  localparam int unsigned       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ctl_valid,
  output logic                    ctl_ready,
  input  logic [2:0]              ctl_op,
  input  logic [NUM_CH-1:0]       ctl_mask,
  input  logic [NUM_CH-1:0]       chk_valid,
  input  logic [NUM_CH-1:0]       chk_pass,
  output logic [NUM_CH-1:0]       fail_pulse,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic [NUM_CH-1:0]       enabled,
  output logic [NUM_CH-1:0]       locked,
  output logic                    first_fail_vld,
  output logic [CH_W-1:0]         first_fail_ch
);

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ON     = 3'd1,
    OP_OFF    = 3'd2,
    OP_KILL   = 3'd3,
    OP_LOCK   = 3'd4,
    OP_UNLOCK = 3'd5,
    OP_CLEAR  = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                       state_q, state_d;
  logic                         ready_q, ready_d;
  logic [CH_W-1:0]              sweep_idx_q, sweep_idx_d;
  logic [NUM_CH-1:0]            sweep_mask_q, sweep_mask_d;
  logic [NUM_CH-1:0]            enabled_q, enabled_d;
  logic [NUM_CH-1:0]            locked_q, locked_d;
  logic [NUM_CH-1:0]            s1_q, s1_d;
  logic [NUM_CH-1:0]            fail_pulse_q, fail_pulse_d;
  logic [CNT_W-1:0]             cnt_q [NUM_CH];
  logic [CNT_W-1:0]             cnt_d [NUM_CH];
  logic                         ff_vld_q, ff_vld_d;
  logic [CH_W-1:0]              ff_ch_q, ff_ch_d;

  op_e                          op;
  logic [NUM_CH-1:0]            free_m;
  logic [NUM_CH-1:0]            kill_m;
  logic [NUM_CH-1:0]            fire;
  logic [NUM_CH-1:0]            sweep_clr;
  logic [CNT_W-1:0]             base;
  logic [CH_W-1:0]              low_ch;
  logic                         low_found;

  // Control decode, enable/lock update, check pipeline and first-failure record
  always_comb begin
    op        = (ctl_valid && ready_q) ? op_e'(ctl_op) : OP_NOP;
    free_m    = ctl_mask & ~locked_q;
    kill_m    = (op == OP_KILL) ? free_m : '0;
    // KILL squashes both the in-flight stage and checks sampled on the same edge
    fire      = s1_q & ~kill_m;
    s1_d      = chk_valid & ~chk_pass & enabled_q & ~kill_m;
    fail_pulse_d = fire;

    enabled_d = enabled_q;
    locked_d  = locked_q;
    case (op)
      OP_ON:          enabled_d = enabled_q | free_m;
      OP_OFF, OP_KILL: enabled_d = enabled_q & ~free_m;
      OP_LOCK:        locked_d  = locked_q | ctl_mask;
      OP_UNLOCK:      locked_d  = locked_q & ~ctl_mask;
      default:        ;
    endcase

    low_ch    = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (fire[i] && !low_found) begin
        low_ch    = CH_W'(i);
        low_found = 1'b1;
      end
    end

    ff_vld_d = ff_vld_q;
    ff_ch_d  = ff_ch_q;
    // A failure reporting on the CLEAR edge is recorded rather than lost
    if (low_found && (!ff_vld_q || op == OP_CLEAR)) begin
      ff_vld_d = 1'b1;
      ff_ch_d  = low_ch;
    end else if (op == OP_CLEAR) begin
      ff_vld_d = 1'b0;
      ff_ch_d  = '0;
    end
  end

  // Counter update: sweep-clear first, then saturating increment on the same edge
  always_comb begin
    sweep_clr = '0;
    base      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sweep_clr[i] = (state_q == SWEEP) && sweep_mask_q[i] && (sweep_idx_q == CH_W'(i));
      base         = sweep_clr[i] ? '0 : cnt_q[i];
      cnt_d[i]     = (fire[i] && (base != '1)) ? base + CNT_W'(1) : base;
    end
  end

  // CLEAR sweep sequencing: one channel per edge, control port held off meanwhile
  always_comb begin
    state_d      = state_q;
    sweep_idx_d  = sweep_idx_q;
    sweep_mask_d = sweep_mask_q;
    case (state_q)
      IDLE: begin
        if (op == OP_CLEAR) begin
          state_d      = SWEEP;
          sweep_idx_d  = '0;
          sweep_mask_d = ctl_mask;
        end
      end
      SWEEP: begin
        if (sweep_idx_q == CH_W'(NUM_CH - 1)) begin
          state_d     = IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      sweep_idx_q  <= '0;
      sweep_mask_q <= '0;
      enabled_q    <= EN_RESET;
      locked_q     <= '0;
      s1_q         <= '0;
      fail_pulse_q <= '0;
      ff_vld_q     <= 1'b0;
      ff_ch_q      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      sweep_idx_q  <= sweep_idx_d;
      sweep_mask_q <= sweep_mask_d;
      enabled_q    <= enabled_d;
      locked_q     <= locked_d;
      s1_q         <= s1_d;
      fail_pulse_q <= fail_pulse_d;
      ff_vld_q     <= ff_vld_d;
      ff_ch_q      <= ff_ch_d;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Output packing
  always_comb begin
    fail_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) fail_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign ctl_ready      = ready_q;
  assign fail_pulse     = fail_pulse_q;
  assign enabled        = enabled_q;
  assign locked         = locked_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_ch  = ff_ch_q;

endmodule

// File: tb/tb_assert_ctl_hub.sv
// Bench for assert_ctl_hub: per-channel behavioural model compared every cycle,
// plus hand-computed checkpoints along directed scenarios.
module tb_assert_ctl_hub;

  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ctl_valid = 1'b0;
  logic              ctl_ready;
  logic [2:0]        ctl_op = '0;
  logic [NCH-1:0]    ctl_mask = '0;
  logic [NCH-1:0]    chk_valid = '0;
  logic [NCH-1:0]    chk_pass = '0;
  logic [NCH-1:0]    fail_pulse;
  logic [NCH*CW-1:0] fail_cnt;
  logic [NCH-1:0]    enabled;
  logic [NCH-1:0]    locked;
  logic              first_fail_vld;
  logic [1:0]        first_fail_ch;

  int n_cmp = 0;
  int n_bad = 0;

  assert_ctl_hub #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
    .ctl_op(ctl_op), .ctl_mask(ctl_mask), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .fail_pulse(fail_pulse), .fail_cnt(fail_cnt), .enabled(enabled), .locked(locked),
    .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch)
  );

  always #5 clk = ~clk;

  // Model state
  bit m_en   [NCH];
  bit m_lock [NCH];
  bit m_s1   [NCH];
  bit m_pulse[NCH];
  int m_cnt  [NCH];
  bit m_smask[NCH];
  int m_sweep_left = 0;
  bit m_ffv = 0;
  int m_ffc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int ch);
    logic [NCH*CW-1:0] v;
    v = fail_cnt;
    return int'(v[ch*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 1'b1; m_lock[i] = 0; m_s1[i] = 0; m_pulse[i] = 0;
      m_cnt[i] = 0; m_smask[i] = 0;
    end
    m_sweep_left = 0; m_ffv = 0; m_ffc = 0;
  endtask

  task automatic model_step();
    bit acc, clr_acc;
    bit kill[NCH];
    bit eff[NCH];
    int sw_ch, low;
    acc = ctl_valid && (m_sweep_left == 0);
    clr_acc = acc && ctl_op == 3'd6;
    for (int i = 0; i < NCH; i++) begin
      kill[i] = acc && ctl_op == 3'd3 && ctl_mask[i] && !m_lock[i];
      eff[i]  = m_s1[i] && !kill[i];
      m_pulse[i] = eff[i];
      m_s1[i] = chk_valid[i] && !chk_pass[i] && m_en[i] && !kill[i];
    end
    sw_ch = (m_sweep_left > 0) ? NCH - m_sweep_left : -1;
    for (int i = 0; i < NCH; i++) begin
      if (i == sw_ch && m_smask[i]) m_cnt[i] = 0;
      if (eff[i] && m_cnt[i] < MAXC) m_cnt[i] = m_cnt[i] + 1;
    end
    low = -1;
    for (int i = NCH - 1; i >= 0; i--) if (eff[i]) low = i;
    if (low >= 0 && (!m_ffv || clr_acc)) begin m_ffv = 1; m_ffc = low; end
    else if (clr_acc) begin m_ffv = 0; m_ffc = 0; end
    if (acc) begin
      for (int i = 0; i < NCH; i++) begin
        if (ctl_mask[i]) begin
          case (ctl_op)
            3'd1: if (!m_lock[i]) m_en[i] = 1;
            3'd2, 3'd3: if (!m_lock[i]) m_en[i] = 0;
            3'd4: m_lock[i] = 1;
            3'd5: m_lock[i] = 0;
            default: ;
          endcase
        end
      end
    end
    if (clr_acc) begin
      m_sweep_left = NCH;
      for (int i = 0; i < NCH; i++) m_smask[i] = ctl_mask[i];
    end else if (m_sweep_left > 0) begin
      m_sweep_left--;
    end
  endtask

  // Compare process: advance the model on each edge/reset, check DUT shortly after
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      check("ready", int'(ctl_ready), int'(m_sweep_left == 0));
      for (int i = 0; i < NCH; i++) begin
        check($sformatf("pulse%0d", i), int'(fail_pulse[i]), int'(m_pulse[i]));
        check($sformatf("cnt%0d", i), cnt_of(i), m_cnt[i]);
        check($sformatf("en%0d", i), int'(enabled[i]), int'(m_en[i]));
        check($sformatf("lock%0d", i), int'(locked[i]), int'(m_lock[i]));
      end
      check("ff_vld", int'(first_fail_vld), int'(m_ffv));
      check("ff_ch", int'(first_fail_ch), m_ffc);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ctl_on(input logic [2:0] op, input logic [NCH-1:0] m);
    ctl_valid = 1'b1; ctl_op = op; ctl_mask = m;
  endtask

  task automatic ctl_off();
    ctl_valid = 1'b0; ctl_op = '0; ctl_mask = '0;
  endtask

  task automatic fail(input logic [NCH-1:0] m);
    chk_valid = m; chk_pass = '0;
  endtask

  task automatic ctl(input logic [2:0] op, input logic [NCH-1:0] m);
    ctl_on(op, m); cyc(1); ctl_off();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("lit_reset_en", int'(enabled), 15);
    check("lit_reset_ready", int'(ctl_ready), 1);
    check("lit_reset_cnt", int'(fail_cnt), 0);

    // Three consecutive failures on ch0
    fail(4'b0001); cyc(3); fail('0); cyc(3);
    check("lit_t1_cnt0", cnt_of(0), 3);
    check("lit_t1_ffv", int'(first_fail_vld), 1);
    check("lit_t1_ffc", int'(first_fail_ch), 0);

    // OFF accepted with same-edge failure: counted; next failure not
    ctl(3'd6, 4'b1111); cyc(5);
    ctl_on(3'd2, 4'b0001); fail(4'b0001); cyc(1);
    ctl_off(); cyc(1); fail('0); cyc(3);
    check("lit_t2_off_cnt0", cnt_of(0), 1);
    ctl_on(3'd1, 4'b0001); fail(4'b0001); cyc(1);
    ctl_off(); fail('0); cyc(3);
    check("lit_t2_on_same_edge", cnt_of(0), 1);
    fail(4'b0001); cyc(1); fail('0); cyc(3);
    check("lit_t2_on_counts", cnt_of(0), 2);

    // KILL squashes in-flight failure; OFF does not
    fail(4'b0100); cyc(1); fail('0); ctl(3'd3, 4'b0100); cyc(3);
    check("lit_t3_kill", cnt_of(2), 0);
    ctl(3'd1, 4'b0100);
    fail(4'b0100); cyc(1); fail('0); ctl(3'd2, 4'b0100); cyc(3);
    check("lit_t3_off", cnt_of(2), 1);
    ctl(3'd1, 4'b0100);

    // LOCK protects enable
    ctl(3'd4, 4'b0010); ctl(3'd2, 4'b1111); cyc(1);
    check("lit_t4_en_locked", int'(enabled), 2);
    check("lit_t4_locked", int'(locked), 2);
    ctl(3'd5, 4'b0010); ctl(3'd2, 4'b1111); cyc(1);
    check("lit_t4_en_unlocked", int'(enabled), 0);
    ctl(3'd1, 4'b1111);

    // Saturation and sweep behaviour on ch3
    fail(4'b1000); cyc(5); fail('0); cyc(3);
    check("lit_t5_sat", cnt_of(3), 3);
    ctl(3'd6, 4'b1000);
    check("lit_t5_ready_low", int'(ctl_ready), 0);
    cyc(2); fail(4'b1000); cyc(1); fail('0); cyc(2);
    check("lit_t5_sweep_inc", cnt_of(3), 1);
    check("lit_t5_ready_back", int'(ctl_ready), 1);
    ctl(3'd6, 4'b0000); cyc(5);
    fail(4'b0110); cyc(1); fail('0); cyc(3);
    check("lit_t5_ffc_low", int'(first_fail_ch), 1);
    // CLEAR on the edge a failure reports: record wins
    fail(4'b0001); cyc(1); fail('0); ctl(3'd6, 4'b0000); cyc(5);
    check("lit_t5_rec_vld", int'(first_fail_vld), 1);
    check("lit_t5_rec_ch", int'(first_fail_ch), 0);

    // NOP / reserved ops accepted with no effect
    ctl(3'd7, 4'b1111); ctl(3'd0, 4'b1111); cyc(1);
    check("lit_t6_nop_en", int'(enabled), 15);

    // Reset during sweep
    fail(4'b1111); ctl(3'd6, 4'b1111); fail('0); cyc(2);
    #3 rst_n = 1'b0;
    #1;
    check("lit_t7_ready", int'(ctl_ready), 1);
    check("lit_t7_cnt", int'(fail_cnt), 0);
    check("lit_t7_en", int'(enabled), 15);
    check("lit_t7_ffv", int'(first_fail_vld), 0);
    cyc(2); rst_n = 1'b1; cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/assert_ctl_hub.md
# assert_ctl_hub

Multi-channel runtime assertion-control hub: collects NUM_CH immediate-check results per clock, gates each by per-channel on/off/kill/lock state driven through a valid/ready control port, and produces registered failure pulses, saturating per-channel failure counters, and a first-failure record. It is the synthesizable, parametrised successor of simulator-level `$asserton`/`$assertoff`/`$assertkill` control. It sits between design-embedded checkers and the debug/status register block.

## Interface
- NUM_CH, 4, number of check channels (1..32)
- CNT_W, 8, width of each failure counter
- EN_RESET, all ones (NUM_CH bits), per-channel enable value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ctl_valid  in  1  control request valid
- ctl_ready  out  1  hub can accept a control request
- ctl_op  in  3  0 NOP, 1 ON, 2 OFF, 3 KILL, 4 LOCK, 5 UNLOCK, 6 CLEAR, 7 reserved (treated as NOP)
- ctl_mask  in  NUM_CH  channels the op applies to
- chk_valid  in  NUM_CH  check evaluated this cycle
- chk_pass  in  NUM_CH  check result (1 = pass); ignored when chk_valid low
- fail_pulse  out  NUM_CH  one-cycle pulse per counted failure
- fail_cnt  out  NUM_CH*CNT_W  counters, channel i at bits [i*CNT_W +: CNT_W]
- enabled  out  NUM_CH  current enable state
- locked  out  NUM_CH  current lock state
- first_fail_vld  out  1  a failure has been recorded since reset/CLEAR
- first_fail_ch  out  $clog2(NUM_CH) (min 1)  channel of first recorded failure

## Operation
- Reset values: enabled=EN_RESET, locked=0, fail_pulse=0, fail_cnt=0, first_fail_vld=0, first_fail_ch=0, ctl_ready=1, FSM IDLE, stage register s1=0.
- Control accepted on an edge where ctl_valid && ctl_ready. FSM: IDLE (ready=1) and SWEEP (ready=0).
- ON/OFF: set/clear enabled for masked channels not locked. Locked channels unaffected.
- KILL: as OFF, plus squashes in-flight failures (s1 bit) and checks sampled on the same edge, for masked unlocked channels.
- LOCK/UNLOCK: set/clear locked for masked channels; never changes enabled.
- CLEAR: clears first_fail_vld/first_fail_ch on the acceptance edge, enters SWEEP; on sweep edge k (k=1..NUM_CH) channel k-1 counter is zeroed if its mask bit (captured at acceptance) is set; after edge NUM_CH return to IDLE.
- Check pipeline: at each edge, s1[i] <= chk_valid[i] && !chk_pass[i] && enabled[i] (enabled value before that edge) and not killed. Next edge: fail_pulse[i] <= s1[i]; counter i increments if s1[i].
- Counters saturate at 2^CNT_W-1; no wrap.
- first_fail: on an edge where any s1 bit is set and first_fail_vld=0, record lowest-index set channel, set vld; held until CLEAR or reset.

## Timing
- Check to fail_pulse/fail_cnt update: 2 edges (sample edge, report edge).
- Control effect: state outputs change on acceptance edge; checks sampled on that same edge use the old enable (OFF: still counted; ON: not counted), except KILL squashes them.
- Simultaneous sweep-clear and increment on same channel/edge: counter becomes 1 (failure not lost). Channels already swept count normally during SWEEP.
- Failures recorded in s1 before an OFF still reach fail_pulse (OFF does not squash); KILL does.
- first_fail cleared by CLEAR on the same edge a failure reports: failure recorded (record wins, vld=1).
- ctl_op ignored while ctl_ready=0; NOP/reserved accepted with no effect, ready stays 1.
- rst_n low mid-SWEEP: asynchronous return to all reset values; sweep abandoned.

## Test plan
- Reset, NUM_CH=4: chk_valid=4'b0001, chk_pass=0 for 3 cycles -> fail_pulse[0] high 3 cycles starting 2 edges later, fail_cnt[0]=3, first_fail_ch=0.
- OFF mask 4'b0001 accepted on same edge as failing check on ch0 -> that failure counted (cnt 1), next failing check not counted; ON restores counting with same-edge check not counted.
- Failing check ch2 sampled, KILL mask 4'b0100 next edge -> no fail_pulse[2], cnt 0; repeat with OFF -> pulse appears.
- LOCK mask 4'b0010 then OFF mask 4'b1111 -> enabled=4'b0010; UNLOCK then OFF -> enabled=0.
- CNT_W=2: 5 failures on ch3 -> fail_cnt[3]=3; CLEAR mask 4'b1000 -> ready low 4 cycles, cnt 0, failure arriving on ch3's sweep edge leaves cnt=1; simultaneous fails ch1+ch2 -> first_fail_ch=1.
- Assert rst_n low during SWEEP -> all outputs at reset values immediately, ready=1.
